// File: rtl/mrd_tag_alloc_arb.sv
// rtl/mrd_tag_alloc_arb.sv - shared PCIe read-tag allocator with round-robin grant and free-list FIFO
module mrd_tag_alloc_arb #(
  parameter int NUM_CHAN = 4,
  parameter int NUM_TAGS = 32,
  parameter int CNT_W    = $clog2(NUM_TAGS + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [NUM_CHAN-1:0] alloc_tag_req_i,
  output logic [NUM_CHAN-1:0] allocated_tag_rdy_o,
  output logic [7:0]          allocated_tag_o,
  input  logic                tag_release_i,
  input  logic [7:0]          tag_release_id_i,
  output logic [CNT_W-1:0]    free_count_o,
  output logic                pool_empty_o,
  output logic                init_done_o,
  output logic                err_bad_release_o
);

  localparam int PTR_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam int CH_W  = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_init_cnt;
  logic [7:0]          r_fifo [NUM_TAGS];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_W-1:0]    r_count;
  logic [NUM_TAGS-1:0] r_outstanding;
  logic [CH_W-1:0]     r_last_winner;
  logic [NUM_CHAN-1:0] r_rdy;
  logic [7:0]          r_tag;
  logic                r_err;

  logic                w_init_wr;
  logic                w_run;
  logic [NUM_CHAN-1:0] w_elig;
  logic                w_grant;
  logic [CH_W-1:0]     w_win_hi;
  logic [CH_W-1:0]     w_win_lo;
  logic                w_any_hi;
  logic [CH_W-1:0]     w_winner;
  logic [7:0]          w_head;
  logic [PTR_W-1:0]    w_head_idx;
  logic [PTR_W-1:0]    w_rel_idx;
  logic                w_rel_in_range;
  logic                w_rel_ok;
  logic                w_push;
  logic [7:0]          w_push_data;
  logic [PTR_W-1:0]    w_wptr_nxt;
  logic [PTR_W-1:0]    w_rptr_nxt;

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= S_INIT;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init_wr   = 1'b0;
    w_run       = 1'b0;
    case (r_state)
      S_INIT: begin
        w_init_wr = 1'b1;
        if (r_init_cnt == 8'(NUM_TAGS - 1)) w_state_nxt = S_RUN;
      end
      S_RUN: w_run = 1'b1;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // The channel holding a grant pulse this cycle still shows its old request; ignore it.
  assign w_elig  = alloc_tag_req_i & ~r_rdy;
  assign w_grant = w_run && (|w_elig) && (r_count != '0);

  // Lowest eligible channel above last_winner wins, else lowest eligible at or below it.
  always_comb begin
    w_win_hi = '0;
    w_win_lo = '0;
    w_any_hi = 1'b0;
    for (int j = NUM_CHAN - 1; j >= 0; j--) begin
      if (w_elig[j]) begin
        if (j > int'(r_last_winner)) begin
          w_any_hi = 1'b1;
          w_win_hi = CH_W'(j);
        end else begin
          w_win_lo = CH_W'(j);
        end
      end
    end
  end

  assign w_winner   = w_any_hi ? w_win_hi : w_win_lo;
  assign w_head     = r_fifo[r_rptr];
  assign w_head_idx = w_head[PTR_W-1:0];

  assign w_rel_idx      = tag_release_id_i[PTR_W-1:0];
  assign w_rel_in_range = int'(tag_release_id_i) < NUM_TAGS;
  assign w_rel_ok       = tag_release_i && w_run && w_rel_in_range && r_outstanding[w_rel_idx];

  assign w_push      = w_init_wr | w_rel_ok;
  assign w_push_data = w_init_wr ? r_init_cnt : tag_release_id_i;
  assign w_wptr_nxt  = (r_wptr == PTR_W'(NUM_TAGS - 1)) ? '0 : r_wptr + 1'b1;
  assign w_rptr_nxt  = (r_rptr == PTR_W'(NUM_TAGS - 1)) ? '0 : r_rptr + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!reset_i && w_push) r_fifo[r_wptr] <= w_push_data;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_init_cnt    <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_last_winner <= CH_W'(NUM_CHAN - 1);
      r_rdy         <= '0;
      r_tag         <= '0;
      r_err         <= 1'b0;
    end else begin
      r_rdy <= '0;
      if (w_init_wr) r_init_cnt <= r_init_cnt + 8'd1;
      if (w_push)    r_wptr     <= w_wptr_nxt;
      if (w_grant) begin
        r_rptr                     <= w_rptr_nxt;
        r_rdy                      <= NUM_CHAN'(1) << w_winner;
        r_tag                      <= w_head;
        r_outstanding[w_head_idx]  <= 1'b1;
        r_last_winner              <= w_winner;
      end
      // A granted head was free, so it can never be the tag being released here.
      if (w_rel_ok) r_outstanding[w_rel_idx] <= 1'b0;
      if (tag_release_i && !w_rel_ok) r_err <= 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_grant);
    end
  end

  assign allocated_tag_rdy_o = r_rdy;
  assign allocated_tag_o     = r_tag;
  assign free_count_o        = r_count;
  assign pool_empty_o        = (r_count == '0);
  assign init_done_o         = (r_state == S_RUN);
  assign err_bad_release_o   = r_err;

endmodule

// File: tb/tb_mrd_tag_alloc_arb.sv
// tb/tb_mrd_tag_alloc_arb.sv - scoreboard bench for mrd_tag_alloc_arb against a queue-based tag pool model
module tb_mrd_tag_alloc_arb;
  localparam int NC = 4;
  localparam int NT = 32;
  localparam int CW = $clog2(NT + 1);

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [NC-1:0] alloc_tag_req_i;
  logic [NC-1:0] allocated_tag_rdy_o;
  logic [7:0]    allocated_tag_o;
  logic          tag_release_i;
  logic [7:0]    tag_release_id_i;
  logic [CW-1:0] free_count_o;
  logic          pool_empty_o;
  logic          init_done_o;
  logic          err_bad_release_o;

  always #5 clk_i = ~clk_i;

  mrd_tag_alloc_arb #(.NUM_CHAN(NC), .NUM_TAGS(NT)) dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .alloc_tag_req_i    (alloc_tag_req_i),
    .allocated_tag_rdy_o(allocated_tag_rdy_o),
    .allocated_tag_o    (allocated_tag_o),
    .tag_release_i      (tag_release_i),
    .tag_release_id_i   (tag_release_id_i),
    .free_count_o       (free_count_o),
    .pool_empty_o       (pool_empty_o),
    .init_done_o        (init_done_o),
    .err_bad_release_o  (err_bad_release_o)
  );

  typedef struct {int ch; int tag;} grant_t;

  int     tests = 0;
  int     fails = 0;
  grant_t exp_q[$];
  grant_t obs_q[$];

  // Reference pool: free tags in FIFO order, per-tag outstanding flag, round-robin pointer.
  int  m_free[$];
  bit  m_out[NT];
  int  m_last;
  int  m_prev;
  bit  m_done;
  int  m_init_n;
  bit  m_err;
  int  m_tag;
  bit  mon_en = 1'b0;

  logic [NC-1:0] want = '0;
  logic [NC-1:0] drop_pend = '0;
  bit            rel_req = 1'b0;
  logic [7:0]    rel_id = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_i) begin
    bit rel_ok;
    int win;
    int c;
    int t;
    if (reset_i) begin
      m_free.delete();
      foreach (m_out[i]) m_out[i] = 1'b0;
      m_last = NC - 1; m_prev = -1; m_done = 1'b0; m_init_n = 0;
      m_err = 1'b0; m_tag = 0;
      exp_q.delete();
      mon_en = 1'b1;
    end else if (!m_done) begin
      m_free.push_back(m_init_n);
      m_init_n++;
      if (m_init_n == NT) m_done = 1'b1;
      if (tag_release_i) m_err = 1'b1;
      m_prev = -1;
    end else begin
      rel_ok = 1'b0;
      if (tag_release_i && int'(tag_release_id_i) < NT) rel_ok = m_out[tag_release_id_i];
      if (tag_release_i && !rel_ok) m_err = 1'b1;
      win = -1;
      if (m_free.size() > 0) begin
        for (int k = 1; k <= NC; k++) begin
          c = (m_last + k) % NC;
          if (win < 0 && alloc_tag_req_i[c] && c != m_prev) win = c;
        end
      end
      m_prev = -1;
      if (win >= 0) begin
        t = m_free.pop_front();
        m_out[t] = 1'b1;
        m_tag = t; m_last = win; m_prev = win;
        exp_q.push_back('{win, t});
      end
      if (rel_ok) begin
        m_out[tag_release_id_i] = 1'b0;
        m_free.push_back(int'(tag_release_id_i));
      end
    end
  end

  always @(negedge clk_i) begin
    grant_t g;
    int ch;
    if (mon_en) begin
      if (allocated_tag_rdy_o != '0) begin
        ch = -1;
        for (int i = 0; i < NC; i++) if (allocated_tag_rdy_o == NC'(1) << i) ch = i;
        obs_q.push_back('{ch, int'(allocated_tag_o)});
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'(allocated_tag_rdy_o), 32'd0);
        end else begin
          g = exp_q.pop_front();
          check("grant_onehot", 32'(allocated_tag_rdy_o), 32'd1 << g.ch);
          check("grant_tag", 32'(allocated_tag_o), 32'(g.tag));
        end
      end else if (exp_q.size() > 0) begin
        g = exp_q.pop_front();
        check("missing_grant", 32'(allocated_tag_rdy_o), 32'd1 << g.ch);
      end
      check("tag_out", 32'(allocated_tag_o), 32'(m_tag));
      check("free_count", 32'(free_count_o), 32'(m_free.size()));
      check("pool_empty", 32'(pool_empty_o), 32'(m_free.size() == 0));
      check("init_done", 32'(init_done_o), 32'(m_done));
      check("err_flag", 32'(err_bad_release_o), 32'(m_err));
    end
  end

  // Requester protocol: raise when wanted, hold through the stale cycle after the grant, then drop.
  task automatic step();
    @(negedge clk_i);
    tag_release_i    = rel_req;
    tag_release_id_i = rel_id;
    rel_req          = 1'b0;
    for (int c = 0; c < NC; c++) begin
      if (drop_pend[c]) begin
        alloc_tag_req_i[c] = 1'b0;
        drop_pend[c] = 1'b0;
      end else if (allocated_tag_rdy_o[c]) begin
        drop_pend[c] = 1'b1;
      end else if (!alloc_tag_req_i[c] && want[c]) begin
        alloc_tag_req_i[c] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic release_tag(input int id);
    rel_req = 1'b1;
    rel_id  = 8'(id);
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},   32'(allocated_tag_rdy_o), 32'd0);
    check({tag, "_tag"},   32'(allocated_tag_o),     32'd0);
    check({tag, "_count"}, 32'(free_count_o),        32'd0);
    check({tag, "_empty"}, 32'(pool_empty_o),        32'd1);
    check({tag, "_done"},  32'(init_done_o),         32'd0);
    check({tag, "_err"},   32'(err_bad_release_o),   32'd0);
  endtask

  task automatic wait_init(input string tag, input bit check_lat);
    int n;
    n = 0;
    while (!init_done_o && n < 100) begin
      step();
      n++;
    end
    if (check_lat) check({tag, "_latency"}, 32'(n), 32'(NT));
    else if (!init_done_o) check({tag, "_timeout"}, 32'(init_done_o), 32'd1);
  endtask

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int n;
    int lst[$];
    reset_i = 1'b1;
    alloc_tag_req_i = '0;
    tag_release_i = 1'b0;
    tag_release_id_i = '0;
    repeat (3) step();
    check_reset_outputs("reset");

    reset_i = 1'b0;
    wait_init("init", 1'b1);
    check("init_count", 32'(free_count_o), 32'(NT));
    check("init_not_empty", 32'(pool_empty_o), 32'd0);

    // Channel 1 alone, two grants.
    obs_q.delete();
    want = 4'b0010;
    n = 0;
    while (obs_q.size() < 2 && n < 40) begin step(); n++; end
    want = '0;
    repeat (4) step();
    check("ch1_grants", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() >= 2) begin
      check("ch1_g0_chan", 32'(obs_q[0].ch), 32'd1);
      check("ch1_g0_tag", 32'(obs_q[0].tag), 32'd0);
      check("ch1_g1_chan", 32'(obs_q[1].ch), 32'd1);
      check("ch1_g1_tag", 32'(obs_q[1].tag), 32'd1);
    end
    check("ch1_count", 32'(free_count_o), 32'(NT - 2));

    // All channels until the pool drains.
    obs_q.delete();
    want = 4'b1111;
    n = 0;
    while (!pool_empty_o && n < 200) begin step(); n++; end
    repeat (8) step();
    check("drain_grants", 32'(obs_q.size()), 32'(NT - 2));
    check("drain_empty", 32'(pool_empty_o), 32'd1);
    if (obs_q.size() >= 9) begin
      for (int i = 0; i < 4; i++) check("drain_tag_order", 32'(obs_q[i].tag), 32'(i + 2));
      for (int i = 0; i < 8; i++) check("drain_rotation", 32'(obs_q[i+1].ch), 32'((obs_q[i].ch + 1) % NC));
    end

    // Release tag 5 into an empty pool with everyone waiting.
    obs_q.delete();
    release_tag(5);
    n = -1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (n < 0 && obs_q.size() > 0) n = i;
    end
    check("regrant_count", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0) check("regrant_tag", 32'(obs_q[0].tag), 32'd5);
    check("regrant_delay", 32'(n), 32'd2);

    // Satisfy the waiting channels, then exercise bad releases.
    want = '0;
    obs_q.delete();
    for (int i = 20; i < 24; i++) release_tag(i);
    repeat (6) step();
    check("waiters_served", 32'(obs_q.size()), 32'd4);
    check("waiters_count", 32'(free_count_o), 32'd0);
    release_tag(7);
    step();
    check("good_release_err", 32'(err_bad_release_o), 32'd0);
    check("good_release_count", 32'(free_count_o), 32'd1);
    release_tag(7);
    release_tag(40);
    step();
    check("bad_release_err", 32'(err_bad_release_o), 32'd1);
    check("bad_release_count", 32'(free_count_o), 32'd1);
    repeat (5) step();
    check("err_sticky", 32'(err_bad_release_o), 32'd1);

    // Grant and valid release on the same edge.
    obs_q.delete();
    want = 4'b0100;
    release_tag(10);
    want = '0;
    step();
    check("simul_count", 32'(free_count_o), 32'd1);
    check("simul_grants", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0) begin
      check("simul_chan", 32'(obs_q[0].ch), 32'd2);
      check("simul_tag", 32'(obs_q[0].tag), 32'd7);
    end
    repeat (4) step();

    // Reset mid-run.
    reset_i = 1'b1;
    repeat (2) step();
    check_reset_outputs("midrun_reset");
    reset_i = 1'b0;
    wait_init("reinit", 1'b1);

    // Randomized traffic with one reset in the middle.
    for (int s = 0; s < 1500; s++) begin
      if ($urandom_range(0, 3) == 0) want = NC'($urandom_range(0, 15));
      if (s == 700 || s == 701) reset_i = 1'b1;
      else reset_i = 1'b0;
      if (m_done && !reset_i && $urandom_range(0, 2) == 0) begin
        lst.delete();
        foreach (m_out[i]) if (m_out[i]) lst.push_back(i);
        if ($urandom_range(0, 63) == 0) begin
          rel_req = 1'b1;
          rel_id  = 8'($urandom_range(0, 255));
        end else if (lst.size() > 0) begin
          rel_req = 1'b1;
          rel_id  = 8'(lst[$urandom_range(0, lst.size() - 1)]);
        end
      end
      step();
    end
    want = '0;
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
